// File: rtl/if_fetch.sv
// rtl/if_fetch.sv - instruction-fetch stage: PC, fetch FSM against a wait-state RAM, single offered slot
// Honours the branch delay slot, stall_pc and MEM-stage ownership of the shared RAM bus.
module if_fetch #(
    parameter logic [15:0] RESET_PC = 16'h0000,
    parameter logic [15:0] NOP_INST = 16'h0800
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall_pc,
    input  logic        branch_flag,
    input  logic [15:0] branch_target,
    input  logic        mem_busy,
    output logic        ram_rd,
    output logic [15:0] ram_addr,
    input  logic        ram_ack,
    input  logic [15:0] ram_rdata,
    output logic [15:0] if_pc,
    output logic [15:0] if_inst,
    output logic        if_valid
);

    typedef enum logic {
        S_FETCH = 1'b0,
        S_OFFER = 1'b1
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [15:0] r_pc;
    logic        r_pend;
    logic [15:0] r_pend_tgt;
    logic        w_ack_ok;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_FETCH;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // A consumed slot is refilled only by an on-path ack; a branch empties it.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_FETCH: if (w_ack_ok) w_state_nxt = S_OFFER;
            S_OFFER: if (!stall_pc && (branch_flag || !w_ack_ok)) w_state_nxt = S_FETCH;
            default: w_state_nxt = S_FETCH;
        endcase
    end

    always_comb begin
        ram_rd   = rst && !mem_busy && (r_state == S_FETCH || !stall_pc);
        ram_addr = r_pc;
        w_ack_ok = ram_rd && ram_ack;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_pc       <= RESET_PC;
            r_pend     <= 1'b0;
            r_pend_tgt <= 16'h0000;
            if_pc      <= 16'h0000;
            if_inst    <= NOP_INST;
            if_valid   <= 1'b0;
        end else begin
            case (r_state)
                S_FETCH: begin
                    if (w_ack_ok) begin
                        if_pc    <= r_pc;
                        if_inst  <= ram_rdata;
                        if_valid <= 1'b1;
                        r_pc     <= branch_flag ? branch_target :
                                    r_pend      ? r_pend_tgt    : r_pc + 16'd1;
                        r_pend   <= 1'b0;
                    end else if (branch_flag) begin
                        // delay slot still in flight: remember where to go once it lands
                        r_pend     <= 1'b1;
                        r_pend_tgt <= branch_target;
                    end
                end
                S_OFFER: begin
                    if (stall_pc) begin
                        if (branch_flag) r_pc <= branch_target;
                    end else if (branch_flag) begin
                        r_pc     <= branch_target;
                        if_valid <= 1'b0;
                        if_inst  <= NOP_INST;
                    end else if (w_ack_ok) begin
                        if_pc    <= r_pc;
                        if_inst  <= ram_rdata;
                        if_valid <= 1'b1;
                        r_pc     <= r_pc + 16'd1;
                    end else begin
                        if_valid <= 1'b0;
                        if_inst  <= NOP_INST;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
